// File: rtl/param_pkg.sv
// Shared parameters and types for the load/store unit: memory range limit, FSM states
// and the funct3 size/sign encoding.
package param_pkg;

    // Highest legal data byte address; consulted only when range checking is built in.
    localparam logic [31:0] D_MEM_MSB = 32'h0000_7FFF;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StFault
    } t_lsu_state;

    typedef enum logic [2:0] {
        FnLb  = 3'b000,
        FnLh  = 3'b001,
        FnLw  = 3'b010,
        FnLbu = 3'b100,
        FnLhu = 3'b101
    } t_lsu_funct3;

    // Store encodings share values with the signed loads.
    localparam t_lsu_funct3 FnSb = FnLb;
    localparam t_lsu_funct3 FnSh = FnLh;
    localparam t_lsu_funct3 FnSw = FnLw;

endpackage

// File: rtl/rvc_lsu_align.sv
// Combinational lane logic: store replication, byte enables, load shift/extend and
// misaligned/illegal/out-of-range detection.
module rvc_lsu_align
    import param_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [31:0] D_MSB    = D_MEM_MSB,
    parameter bit          RangeChk = 1'b0
) (
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [31:0]       rd_word_i,
    output logic [3:0]        byte_en_o,
    output logic [31:0]       st_data_o,
    output logic [31:0]       ld_data_o,
    output logic              fault_o
);

    localparam logic [ADDR_W-1:0] Limit = ADDR_W'(D_MSB);

    logic [1:0]  lane;
    logic        legal;
    logic        misal;
    logic        word_acc;
    logic        range_bad;
    logic [31:0] shifted;

    assign lane = addr_i[1:0];

    always_comb begin
        legal     = 1'b0;
        misal     = 1'b0;
        word_acc  = 1'b0;
        byte_en_o = 4'b0000;
        st_data_o = st_data_i;
        case (funct3_i)
            FnLb: begin
                legal     = 1'b1;
                byte_en_o = 4'b0001 << lane;
                st_data_o = {4{st_data_i[7:0]}};
            end
            FnLh: begin
                legal     = 1'b1;
                misal     = lane[0];
                byte_en_o = 4'b0011 << {lane[1], 1'b0};
                st_data_o = {2{st_data_i[15:0]}};
            end
            FnLw: begin
                legal     = 1'b1;
                misal     = (lane != 2'b00);
                word_acc  = 1'b1;
                byte_en_o = 4'b1111;
            end
            FnLbu: begin
                legal     = !is_store_i;
                byte_en_o = 4'b0001 << lane;
            end
            FnLhu: begin
                legal     = !is_store_i;
                misal     = lane[0];
                byte_en_o = 4'b0011 << {lane[1], 1'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    assign range_bad = (addr_i > Limit) || (word_acc && ((addr_i | ADDR_W'(3)) > Limit));
    assign fault_o   = !legal || misal || (RangeChk && range_bad);

    assign shifted = rd_word_i >> {lane, 3'b000};

    always_comb begin
        ld_data_o = shifted;
        case (funct3_i)
            FnLb:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            FnLh:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            FnLbu:   ld_data_o = {24'h0, shifted[7:0]};
            FnLhu:   ld_data_o = {16'h0, shifted[15:0]};
            default: ld_data_o = shifted;
        endcase
    end

endmodule

// File: rtl/rvc_lsu.sv
// Multi-cycle load/store unit: one op per handshake, single aligned memory request.
// Optional build macro RVC_LSU_RANGE_CHK_EN faults accesses beyond D_MSB.
module rvc_lsu
    import param_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter logic [31:0] D_MSB  = D_MEM_MSB
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              LsuValid,
    output logic              LsuReady,
    input  logic              LsuIsStore,
    input  logic [2:0]        LsuFunct3,
    input  logic [ADDR_W-1:0] LsuAddr,
    input  logic [31:0]       LsuWrData,
    input  logic [4:0]        LsuRdIdx,
    output logic              WbValid,
    output logic [4:0]        WbRdIdx,
    output logic [31:0]       WbData,
    output logic              LsuFault,
    output logic              DMemReq,
    output logic              DMemWe,
    output logic [3:0]        DMemByteEn,
    output logic [ADDR_W-1:0] DMemAddr,
    output logic [31:0]       DMemWrData,
    input  logic              DMemAck,
    input  logic [31:0]       DMemRdData
);

`ifdef RVC_LSU_RANGE_CHK_EN
    localparam bit RangeChk = 1'b1;
`else
    localparam bit RangeChk = 1'b0;
`endif

    t_lsu_state state_q, state_d;

    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [4:0]        rd_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       wb_data_q;

    logic              idle;
    logic              accept;
    logic              op_is_store;
    logic [2:0]        op_funct3;
    logic [ADDR_W-1:0] op_addr;
    logic [3:0]        al_be;
    logic [31:0]       al_st;
    logic [31:0]       al_ld;
    logic              al_fault;

    assign idle   = (state_q == StIdle);
    assign accept = idle && LsuValid;

    // Live inputs decide legality at accept; captured op drives load alignment later.
    assign op_is_store = idle ? LsuIsStore : is_store_q;
    assign op_funct3   = idle ? LsuFunct3  : funct3_q;
    assign op_addr     = idle ? LsuAddr    : addr_q;

    rvc_lsu_align #(
        .ADDR_W   (ADDR_W),
        .D_MSB    (D_MSB),
        .RangeChk (RangeChk)
    ) u_align (
        .is_store_i (op_is_store),
        .funct3_i   (op_funct3),
        .addr_i     (op_addr),
        .st_data_i  (LsuWrData),
        .rd_word_i  (DMemRdData),
        .byte_en_o  (al_be),
        .st_data_o  (al_st),
        .ld_data_o  (al_ld),
        .fault_o    (al_fault)
    );

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q    <= StIdle;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            rd_q       <= 5'd0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            wb_data_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q <= LsuIsStore;
                funct3_q   <= LsuFunct3;
                addr_q     <= LsuAddr;
                rd_q       <= LsuRdIdx;
                be_q       <= al_be;
                wdata_q    <= al_st;
            end
            if ((state_q == StReq) && DMemAck && !is_store_q) begin
                wb_data_q <= al_ld;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (LsuValid) begin
                    state_d = al_fault ? StFault : StReq;
                end
            end
            StReq: begin
                if (DMemAck) begin
                    state_d = is_store_q ? StIdle : StResp;
                end
            end
            StResp:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        LsuReady   = idle;
        DMemReq    = (state_q == StReq);
        DMemWe     = (state_q == StReq) && is_store_q;
        DMemByteEn = (state_q == StReq) ? be_q : 4'b0000;
        DMemAddr   = {addr_q[ADDR_W-1:2], 2'b00};
        DMemWrData = wdata_q;
        WbValid    = (state_q == StResp) && (rd_q != 5'd0);
        WbRdIdx    = rd_q;
        WbData     = wb_data_q;
        LsuFault   = (state_q == StFault);
    end

endmodule

// File: tb/tb_rvc_lsu.sv
// Directed bench for rvc_lsu: stores, loads with extension, faults, rd=0, reset abort.
module tb_rvc_lsu;

    localparam int unsigned ADDR_W = 32;

    logic              Clock = 1'b0;
    logic              Rst;
    logic              LsuValid;
    logic              LsuReady;
    logic              LsuIsStore;
    logic [2:0]        LsuFunct3;
    logic [ADDR_W-1:0] LsuAddr;
    logic [31:0]       LsuWrData;
    logic [4:0]        LsuRdIdx;
    logic              WbValid;
    logic [4:0]        WbRdIdx;
    logic [31:0]       WbData;
    logic              LsuFault;
    logic              DMemReq;
    logic              DMemWe;
    logic [3:0]        DMemByteEn;
    logic [ADDR_W-1:0] DMemAddr;
    logic [31:0]       DMemWrData;
    logic              DMemAck;
    logic [31:0]       DMemRdData;

    int passed = 0;
    int total  = 0;

    rvc_lsu #(
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .LsuValid   (LsuValid),
        .LsuReady   (LsuReady),
        .LsuIsStore (LsuIsStore),
        .LsuFunct3  (LsuFunct3),
        .LsuAddr    (LsuAddr),
        .LsuWrData  (LsuWrData),
        .LsuRdIdx   (LsuRdIdx),
        .WbValid    (WbValid),
        .WbRdIdx    (WbRdIdx),
        .WbData     (WbData),
        .LsuFault   (LsuFault),
        .DMemReq    (DMemReq),
        .DMemWe     (DMemWe),
        .DMemByteEn (DMemByteEn),
        .DMemAddr   (DMemAddr),
        .DMemWrData (DMemWrData),
        .DMemAck    (DMemAck),
        .DMemRdData (DMemRdData)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // Present one op at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd);
        LsuValid   = 1'b1;
        LsuIsStore = st;
        LsuFunct3  = f3;
        LsuAddr    = addr;
        LsuWrData  = wd;
        LsuRdIdx   = rd;
        chk("ready_at_issue", {31'h0, LsuReady}, 32'h1);
        tick();
        LsuValid = 1'b0;
    endtask

    initial begin
        Rst        = 1'b1;
        LsuValid   = 1'b0;
        LsuIsStore = 1'b0;
        LsuFunct3  = 3'b000;
        LsuAddr    = '0;
        LsuWrData  = 32'h0;
        LsuRdIdx   = 5'd0;
        DMemAck    = 1'b0;
        DMemRdData = 32'h0;
        tick();
        tick();
        Rst = 1'b0;

        chk("rst_ready",  {31'h0, LsuReady}, 32'h1);
        chk("rst_req",    {31'h0, DMemReq},  32'h0);
        chk("rst_we",     {31'h0, DMemWe},   32'h0);
        chk("rst_wb",     {31'h0, WbValid},  32'h0);
        chk("rst_fault",  {31'h0, LsuFault}, 32'h0);
        chk("rst_be",     {28'h0, DMemByteEn}, 32'h0);
        chk("rst_addr",   DMemAddr,   32'h0);
        chk("rst_wdata",  DMemWrData, 32'h0);
        chk("rst_wbdata", WbData,     32'h0);

        // SW 0x100, ack in third REQ cycle
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 5'd0);
        for (int i = 0; i < 3; i++) begin
            chk("sw_req",   {31'h0, DMemReq},    32'h1);
            chk("sw_we",    {31'h0, DMemWe},     32'h1);
            chk("sw_be",    {28'h0, DMemByteEn}, 32'hF);
            chk("sw_wdata", DMemWrData, 32'hDEAD_BEEF);
            chk("sw_addr",  DMemAddr,   32'h100);
            chk("sw_ready", {31'h0, LsuReady},   32'h0);
            chk("sw_wb",    {31'h0, WbValid},    32'h0);
            if (i == 2) DMemAck = 1'b1;
            tick();
        end
        DMemAck = 1'b0;
        chk("sw_done_req",   {31'h0, DMemReq},  32'h0);
        chk("sw_done_ready", {31'h0, LsuReady}, 32'h1);
        chk("sw_done_wb",    {31'h0, WbValid},  32'h0);

        // LB 0x103 rd=5, ack in first REQ cycle
        issue(1'b0, 3'b000, 32'h103, 32'h0, 5'd5);
        chk("lb_req",  {31'h0, DMemReq},    32'h1);
        chk("lb_we",   {31'h0, DMemWe},     32'h0);
        chk("lb_addr", DMemAddr, 32'h100);
        chk("lb_be",   {28'h0, DMemByteEn}, 32'h8);
        DMemAck    = 1'b1;
        DMemRdData = 32'h80FF_0000;
        tick();
        DMemAck = 1'b0;
        chk("lb_wbv",   {31'h0, WbValid},  32'h1);
        chk("lb_rd",    {27'h0, WbRdIdx},  32'd5);
        chk("lb_data",  WbData, 32'hFFFF_FF80);
        chk("lb_ready", {31'h0, LsuReady}, 32'h0);
        tick();
        chk("lb_wb_off", {31'h0, WbValid},  32'h0);
        chk("lb_idle",   {31'h0, LsuReady}, 32'h1);

        // LBU same address
        issue(1'b0, 3'b100, 32'h103, 32'h0, 5'd6);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        chk("lbu_wbv",  {31'h0, WbValid}, 32'h1);
        chk("lbu_data", WbData, 32'h0000_0080);
        tick();

        // LH / LHU upper half, sign bit set
        DMemRdData = 32'h9234_5678;
        issue(1'b0, 3'b001, 32'h102, 32'h0, 5'd7);
        chk("lh_be", {28'h0, DMemByteEn}, 32'hC);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        chk("lh_data", WbData, 32'hFFFF_9234);
        tick();
        issue(1'b0, 3'b101, 32'h102, 32'h0, 5'd7);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        chk("lhu_data", WbData, 32'h0000_9234);
        tick();

        // SH 0x102
        issue(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, 5'd0);
        chk("sh_be",    {28'h0, DMemByteEn}, 32'hC);
        chk("sh_wdata", DMemWrData, 32'hABCD_ABCD);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        chk("sh_done", {31'h0, LsuReady}, 32'h1);

        // LH misaligned -> fault, no request
        issue(1'b0, 3'b001, 32'h101, 32'h0, 5'd3);
        chk("lh_mis_fault", {31'h0, LsuFault}, 32'h1);
        chk("lh_mis_req",   {31'h0, DMemReq},  32'h0);
        chk("lh_mis_ready", {31'h0, LsuReady}, 32'h0);
        tick();
        chk("lh_mis_fault_off", {31'h0, LsuFault}, 32'h0);
        chk("lh_mis_req_off",   {31'h0, DMemReq},  32'h0);
        chk("lh_mis_idle",      {31'h0, LsuReady}, 32'h1);

        // Illegal store funct3 100 -> fault
        issue(1'b1, 3'b100, 32'h100, 32'h0, 5'd0);
        chk("ill_fault", {31'h0, LsuFault}, 32'h1);
        chk("ill_req",   {31'h0, DMemReq},  32'h0);
        tick();

        // LW misaligned -> fault
        issue(1'b0, 3'b010, 32'h102, 32'h0, 5'd1);
        chk("lw_mis_fault", {31'h0, LsuFault}, 32'h1);
        tick();

        // LW rd=0: access performed, no writeback; then back-to-back SB
        issue(1'b0, 3'b010, 32'h200, 32'h0, 5'd0);
        chk("lw0_req",  {31'h0, DMemReq}, 32'h1);
        chk("lw0_addr", DMemAddr, 32'h200);
        DMemAck    = 1'b1;
        DMemRdData = 32'h1234_5678;
        tick();
        DMemAck = 1'b0;
        chk("lw0_wb",    {31'h0, WbValid},  32'h0);
        chk("lw0_ready", {31'h0, LsuReady}, 32'h0);
        tick();
        issue(1'b1, 3'b000, 32'h201, 32'h0000_005A, 5'd0);
        chk("sb_req",   {31'h0, DMemReq},    32'h1);
        chk("sb_be",    {28'h0, DMemByteEn}, 32'h2);
        chk("sb_wdata", DMemWrData, 32'h5A5A_5A5A);
        chk("sb_addr",  DMemAddr, 32'h200);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;

        // Reset during REQ, late ack ignored
        issue(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
        chk("abort_req", {31'h0, DMemReq}, 32'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("abort_req_off", {31'h0, DMemReq},  32'h0);
        chk("abort_ready",   {31'h0, LsuReady}, 32'h1);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        chk("late_ack_req",   {31'h0, DMemReq},  32'h0);
        chk("late_ack_wb",    {31'h0, WbValid},  32'h0);
        chk("late_ack_ready", {31'h0, LsuReady}, 32'h1);
        tick();
        chk("late_ack_wb2", {31'h0, WbValid}, 32'h0);

`ifdef RVC_LSU_RANGE_CHK_EN
        issue(1'b0, 3'b010, 32'h8000, 32'h0, 5'd2);
        chk("range_fault", {31'h0, LsuFault}, 32'h1);
        chk("range_noreq", {31'h0, DMemReq},  32'h0);
        tick();
        issue(1'b0, 3'b010, 32'h7FFC, 32'h0, 5'd2);
        chk("range_ok_req",   {31'h0, DMemReq},  32'h1);
        chk("range_ok_fault", {31'h0, LsuFault}, 32'h0);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        tick();
`else
        issue(1'b0, 3'b010, 32'h8000, 32'h0, 5'd2);
        chk("nochk_req",  {31'h0, DMemReq},  32'h1);
        chk("nochk_addr", DMemAddr, 32'h8000);
        DMemAck = 1'b1;
        tick();
        DMemAck = 1'b0;
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
